// File: rtl/systolic_pkg.sv
// systolic_pkg: shared encodings and arbiter state type for the systolic array control path
package systolic_pkg;
    localparam logic [1:0] SA_OP_MATMUL = 2'd0;
    localparam logic [1:0] SA_OP_CONV   = 2'd1;
    localparam logic [1:0] SA_OP_IDLE   = 2'd2;
    localparam int SA_MAX_DIM = 16;
    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_ISSUE    = 2'd1,
        ARB_WAIT     = 2'd2,
        ARB_COMPLETE = 2'd3
    } arb_state_e;
endpackage

// File: rtl/systolic_job_arbiter_if.sv
// systolic_job_arbiter_if: requester job/completion bus plus systolic_array control port
// slave  : arbiter view (accepts jobs, drives array controls and completions)
// master : environment view (requesters and array model)
interface systolic_job_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [2*NUM_REQ-1:0]       req_op;
    logic [4*NUM_REQ-1:0]       req_rows;
    logic [4*NUM_REQ-1:0]       req_cols;
    logic [NUM_REQ-1:0]         cpl_valid;
    logic                       cpl_error;
    logic [31:0]                cpl_cycles;
    logic                       sa_start;
    logic [1:0]                 sa_operation;
    logic [3:0]                 sa_rows;
    logic [3:0]                 sa_cols;
    logic                       sa_done;
    logic [31:0]                sa_cycle_count;
    logic                       busy;
    logic [$clog2(NUM_REQ)-1:0] owner;
    modport slave (
        input  req_valid, req_op, req_rows, req_cols, sa_done, sa_cycle_count,
        output req_ready, cpl_valid, cpl_error, cpl_cycles, sa_start,
               sa_operation, sa_rows, sa_cols, busy, owner
    );
    modport master (
        output req_valid, req_op, req_rows, req_cols, sa_done, sa_cycle_count,
        input  req_ready, cpl_valid, cpl_error, cpl_cycles, sa_start,
               sa_operation, sa_rows, sa_cols, busy, owner
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, first set request at or after ptr_i
// req_i : request vector
// ptr_i : highest-priority index
// gnt_o : one-hot grant (zero when no request)
// idx_o : index of the granted request (zero when no request)
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [W-1:0]       ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [W-1:0]       idx_o
);
    logic         found;
    logic [W-1:0] j;
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = W'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end
endmodule

// File: rtl/systolic_job_arbiter.sv
// systolic_job_arbiter: round-robin job sequencer sharing one systolic_array among NUM_REQ requesters
// clk, rst : clock and asynchronous active-high reset
// bus      : slave side of systolic_job_arbiter_if (job handshake, completions, array control, status)
// Optional watchdog on sa_done enabled by defining SYSTOLIC_ARB_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module systolic_job_arbiter
    import systolic_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input logic                   clk,
    input logic                   rst,
    systolic_job_arbiter_if.slave bus
);
    localparam int W = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [W-1:0]       rr_ptr_q, rr_ptr_d, owner_q, owner_d, win_idx;
    logic [NUM_REQ-1:0] win_gnt;
    logic [1:0]         op_q, op_d, win_op;
    logic [3:0]         rows_q, rows_d, cols_q, cols_d, win_rows, win_cols;
    logic               cpl_error_q, cpl_error_d;
    logic [31:0]        cpl_cycles_q, cpl_cycles_d;
    logic               idle, accept, legal, done_ev, timeout;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (win_gnt),
        .idx_o (win_idx)
    );

    assign idle    = state_q == ARB_IDLE;
    assign accept  = idle && |bus.req_valid;
    assign legal   = win_op < SA_OP_IDLE && win_rows != 4'd0 && win_cols != 4'd0;
    assign done_ev = state_q == ARB_WAIT && bus.sa_done;

`ifdef SYSTOLIC_ARB_TIMEOUT_EN
    logic [31:0] wd_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wd_q <= '0;
        else     wd_q <= (state_q == ARB_WAIT) ? wd_q + 32'd1 : '0;
    end
    // Fires on the TIMEOUT_CYCLES-th WAIT cycle; a same-cycle sa_done wins.
    assign timeout = state_q == ARB_WAIT && !bus.sa_done && wd_q == 32'(TIMEOUT_CYCLES - 1);
`else
    // Watchdog compiled out: constant-false, WAIT ends only on sa_done.
    assign timeout = TIMEOUT_CYCLES < 0;
`endif

    always_comb begin
        win_op   = '0;
        win_rows = '0;
        win_cols = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (W'(i) == win_idx) begin
                win_op   = bus.req_op[2*i +: 2];
                win_rows = bus.req_rows[4*i +: 4];
                win_cols = bus.req_cols[4*i +: 4];
            end
        end
        state_d = idle                    ? (accept ? (legal ? ARB_ISSUE : ARB_COMPLETE) : ARB_IDLE) :
                  (state_q == ARB_ISSUE)  ? ARB_WAIT :
                  (state_q == ARB_WAIT)   ? ((done_ev || timeout) ? ARB_COMPLETE : ARB_WAIT) :
                                            ARB_IDLE;
        rr_ptr_d = (state_q == ARB_COMPLETE) ? ((owner_q == W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1) : rr_ptr_q;
        owner_d  = accept ? win_idx  : owner_q;
        op_d     = accept ? win_op   : op_q;
        rows_d   = accept ? win_rows : rows_q;
        cols_d   = accept ? win_cols : cols_q;
        cpl_error_d  = (accept && !legal) ? 1'b1 : done_ev ? 1'b0 : timeout ? 1'b1 : cpl_error_q;
        cpl_cycles_d = (accept && !legal) ? '0 : done_ev ? bus.sa_cycle_count : timeout ? '0 : cpl_cycles_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            op_q         <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            cpl_error_q  <= 1'b0;
            cpl_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            cpl_error_q  <= cpl_error_d;
            cpl_cycles_q <= cpl_cycles_d;
        end
    end

    // Ready is forced low during reset since the arbitration itself is combinational.
    assign bus.req_ready    = (idle && !rst) ? win_gnt : '0;
    assign bus.cpl_valid    = (state_q == ARB_COMPLETE) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q) : '0;
    assign bus.cpl_error    = cpl_error_q;
    assign bus.cpl_cycles   = cpl_cycles_q;
    assign bus.sa_start     = state_q == ARB_ISSUE;
    assign bus.sa_operation = op_q;
    assign bus.sa_rows      = rows_q;
    assign bus.sa_cols      = cols_q;
    assign bus.busy         = !idle;
    assign bus.owner        = owner_q;
endmodule

// File: tb/tb_systolic_job_arbiter.sv
// tb_systolic_job_arbiter: directed vector bench for systolic_job_arbiter
module tb_systolic_job_arbiter;
`ifdef SYSTOLIC_ARB_TIMEOUT_EN
    localparam int TO = 50;
`else
    localparam int TO = 1023;
`endif
    localparam int DONE_DLY = 20;

    typedef struct {
        logic        rst_first;
        logic [3:0]  valid;
        logic [1:0]  op;
        logic [3:0]  rows;
        logic [3:0]  cols;
        logic [31:0] count;
        logic [3:0]  exp_rdy;
        logic [1:0]  exp_owner;
        logic        exp_err;
        logic [31:0] exp_cycles;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    int   start_cnt = 0;
    int   cpl_cnt = 0;
    vec_t vecs[11];

    systolic_job_arbiter_if #(.NUM_REQ(4)) bus();

    systolic_job_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.sa_start) start_cnt <= start_cnt + 1;
        if (|bus.cpl_valid) cpl_cnt <= cpl_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [3:0] valid, input logic [1:0] op, input logic [3:0] rows, input logic [3:0] cols);
        bus.req_valid = valid;
        bus.req_op    = {4{op}};
        bus.req_rows  = {4{rows}};
        bus.req_cols  = {4{cols}};
    endtask

    task automatic wait_cpl(output int n, input int limit);
        n = 0;
        while (bus.cpl_valid == 4'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_job(input vec_t v);
        int n;
        int s0;
        if (v.rst_first) begin
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        @(negedge clk);
        drive(v.valid, v.op, v.rows, v.cols);
        bus.sa_cycle_count = v.count;
        s0 = start_cnt;
        #1;
        chk("req_ready", {28'd0, bus.req_ready}, {28'd0, v.exp_rdy});
        @(negedge clk);
        chk("owner", {30'd0, bus.owner}, {30'd0, v.exp_owner});
        chk("busy after accept", {31'd0, bus.busy}, 32'd1);
        chk("sa_start after accept", {31'd0, bus.sa_start}, {31'd0, !v.exp_err});
        if (!v.exp_err) begin
            chk("sa descriptor", {22'd0, bus.sa_operation, bus.sa_rows, bus.sa_cols}, {22'd0, v.op, v.rows, v.cols});
            repeat (DONE_DLY) @(negedge clk);
            bus.sa_done = 1'b1;
            @(negedge clk);
            bus.sa_done = 1'b0;
        end
        wait_cpl(n, 100);
        chk("cpl latency", n, 0);
        chk("cpl_valid", {28'd0, bus.cpl_valid}, {28'd0, 4'b0001 << v.exp_owner});
        chk("cpl_error", {31'd0, bus.cpl_error}, {31'd0, v.exp_err});
        chk("cpl_cycles", bus.cpl_cycles, v.exp_cycles);
        chk("ready during cpl", {28'd0, bus.req_ready}, 32'd0);
        chk("sa_start count", start_cnt - s0, v.exp_err ? 0 : 1);
        @(negedge clk);
        chk("idle after cpl", {31'd0, bus.busy}, 32'd0);
        bus.req_valid = 4'b0;
    endtask

    initial begin
        int   n;
        int   c0;
        vec_t hv;
        vecs[0]  = '{1'b0, 4'b0001, 2'd0, 4'd4,  4'd4,  32'd37,    4'b0001, 2'd0, 1'b0, 32'd37};
        vecs[1]  = '{1'b1, 4'b1111, 2'd0, 4'd2,  4'd3,  32'd100,   4'b0001, 2'd0, 1'b0, 32'd100};
        vecs[2]  = '{1'b0, 4'b1111, 2'd1, 4'd5,  4'd6,  32'd101,   4'b0010, 2'd1, 1'b0, 32'd101};
        vecs[3]  = '{1'b0, 4'b1111, 2'd0, 4'd7,  4'd8,  32'd102,   4'b0100, 2'd2, 1'b0, 32'd102};
        vecs[4]  = '{1'b0, 4'b1111, 2'd1, 4'd9,  4'd10, 32'd103,   4'b1000, 2'd3, 1'b0, 32'd103};
        vecs[5]  = '{1'b0, 4'b1111, 2'd0, 4'd15, 4'd15, 32'd104,   4'b0001, 2'd0, 1'b0, 32'd104};
        vecs[6]  = '{1'b0, 4'b0010, 2'd2, 4'd4,  4'd4,  32'd999,   4'b0010, 2'd1, 1'b1, 32'd0};
        vecs[7]  = '{1'b0, 4'b0100, 2'd0, 4'd0,  4'd4,  32'd999,   4'b0100, 2'd2, 1'b1, 32'd0};
        vecs[8]  = '{1'b0, 4'b1000, 2'd1, 4'd4,  4'd0,  32'd999,   4'b1000, 2'd3, 1'b1, 32'd0};
        vecs[9]  = '{1'b0, 4'b1001, 2'd3, 4'd1,  4'd1,  32'd999,   4'b0001, 2'd0, 1'b1, 32'd0};
        vecs[10] = '{1'b0, 4'b0110, 2'd1, 4'd15, 4'd1,  32'd12345, 4'b0010, 2'd1, 1'b0, 32'd12345};

        drive(4'b1111, 2'd0, 4'd4, 4'd4);
        bus.sa_done = 1'b0;
        bus.sa_cycle_count = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst req_ready", {28'd0, bus.req_ready}, 32'd0);
        chk("rst busy", {31'd0, bus.busy}, 32'd0);
        chk("rst owner", {30'd0, bus.owner}, 32'd0);
        chk("rst sa ctrl", {21'd0, bus.sa_start, bus.sa_operation, bus.sa_rows, bus.sa_cols}, 32'd0);
        chk("rst cpl", {27'd0, bus.cpl_valid, bus.cpl_error}, 32'd0);
        chk("rst cpl_cycles", bus.cpl_cycles, 32'd0);
        bus.req_valid = 4'b0;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) do_job(vecs[i]);

        // spurious sa_done while idle
        @(negedge clk);
        c0 = cpl_cnt;
        bus.sa_done = 1'b1;
        bus.sa_cycle_count = 32'd77;
        @(negedge clk);
        bus.sa_done = 1'b0;
        chk("spurious busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        chk("spurious cpl", cpl_cnt - c0, 0);
        chk("cpl_cycles hold", bus.cpl_cycles, 32'd12345);

        // reset during WAIT
        drive(4'b0010, 2'd0, 4'd3, 4'd3);
        @(negedge clk);
        chk("midjob start", {31'd0, bus.sa_start}, 32'd1);
        repeat (5) @(negedge clk);
        chk("midjob busy", {31'd0, bus.busy}, 32'd1);
        chk("ready while busy", {28'd0, bus.req_ready}, 32'd0);
        c0 = cpl_cnt;
        rst = 1'b1;
        #1;
        chk("midrst busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst ready", {28'd0, bus.req_ready}, 32'd0);
        chk("midrst sa_rows", {28'd0, bus.sa_rows}, 32'd0);
        chk("midrst cpl_cycles", bus.cpl_cycles, 32'd0);
        bus.req_valid = 4'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.sa_done = 1'b1;
        @(negedge clk);
        bus.sa_done = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst no cpl", cpl_cnt - c0, 0);
        bus.req_valid = 4'b1111;
        #1;
        chk("midrst rr_ptr", {28'd0, bus.req_ready}, 32'b0001);
        bus.req_valid = 4'b0;
        hv = '{1'b0, 4'b0100, 2'd0, 4'd4, 4'd4, 32'd55, 4'b0100, 2'd2, 1'b0, 32'd55};
        do_job(hv);

        // long wait on sa_done
        @(negedge clk);
        drive(4'b0001, 2'd0, 4'd4, 4'd4);
        @(negedge clk);
        bus.req_valid = 4'b0;
        chk("wd start", {31'd0, bus.sa_start}, 32'd1);
`ifdef SYSTOLIC_ARB_TIMEOUT_EN
        wait_cpl(n, 200);
        chk("wd latency", {31'd0, (n >= 49 && n <= 53)}, 32'd1);
        chk("wd cpl_valid", {28'd0, bus.cpl_valid}, 32'b0001);
        chk("wd cpl_error", {31'd0, bus.cpl_error}, 32'd1);
        chk("wd cpl_cycles", bus.cpl_cycles, 32'd0);
        @(negedge clk);
        c0 = cpl_cnt;
        bus.sa_done = 1'b1;
        bus.sa_cycle_count = 32'd88;
        @(negedge clk);
        bus.sa_done = 1'b0;
        @(negedge clk);
        chk("late done ignored", cpl_cnt - c0, 0);
        chk("late done cycles", bus.cpl_cycles, 32'd0);
`else
        c0 = cpl_cnt;
        repeat (1000) @(negedge clk);
        chk("no wd busy", {31'd0, bus.busy}, 32'd1);
        chk("no wd cpl", cpl_cnt - c0, 0);
        bus.sa_done = 1'b1;
        bus.sa_cycle_count = 32'd1002;
        @(negedge clk);
        bus.sa_done = 1'b0;
        wait_cpl(n, 100);
        chk("no wd latency", n, 0);
        chk("no wd cpl_error", {31'd0, bus.cpl_error}, 32'd0);
        chk("no wd cpl_cycles", bus.cpl_cycles, 32'd1002);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
